dmem_responder: RTL

- Memory-side responder for the core's data-memory port.
- Accepts word-aligned load/store requests carrying a 4-bit byte-lane write mask and pre-shifted store data, produced by the core's load/store alignment logic.
- Commits byte-masked writes to an internal word array and returns whole read words after a programmable latency.
- Sits between the core's load/store path and on-chip data RAM; word-to-byte extraction for loads stays on the core side.

---
 rtl/dmem_responder_pkg.sv | 40 ++++
 rtl/dmem_byte_ram.sv | 33 +++
 rtl/dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
// Optional DMEM_ALIGN_CHECK_EN faults stores with irregular byte enables.
package dmem_responder_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam byte_en_t BE_B0 = 4'b0001;
  localparam byte_en_t BE_B1 = 4'b0010;
  localparam byte_en_t BE_B2 = 4'b0100;
  localparam byte_en_t BE_B3 = 4'b1000;
  localparam byte_en_t BE_H0 = 4'b0011;
  localparam byte_en_t BE_H1 = 4'b1100;
  localparam byte_en_t BE_W  = 4'b1111;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  function automatic logic be_legal(input byte_en_t be);
    logic ok;
    ok = 1'b0;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3,
      BE_H0, BE_H1, BE_W: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word array with per-lane write mask and registered read port.
// Contents are deliberately not reset.
module dmem_byte_ram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  byte_en_t      be,
  input  logic [AW-1:0] addr,
  input  data_t         wdata,
  output data_t         rdata
);

  data_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: decode, fault check, latency FSM, RAM.
// Build with DMEM_ALIGN_CHECK_EN to fault irregular store byte enables.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter addr_t BASE_ADDR   = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     req_valid,
  output logic     req_ready,
  input  addr_t    req_addr,
  input  logic     req_we,
  input  byte_en_t req_be,
  input  data_t    req_wdata,
  output logic     rsp_valid,
  input  logic     rsp_ready,
  output data_t    rsp_rdata,
  output logic     rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_INIT =
    (LATENCY > 2) ? CW'(LATENCY - 2) : '0;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd_sel;
  data_t         ram_rdata;

  addr_t off;
  logic  oor;
  logic  be_bad;
  logic  fault;
  logic  accept;
  logic  ram_we;
  logic  ram_re;

  assign off    = req_addr - BASE_ADDR;
  assign oor    = (req_addr < BASE_ADDR) || ((off >> 2) >= DEPTH_L);
  assign be_bad = ALIGN_CHECK && req_we && !be_legal(req_be);
  assign fault  = oor || be_bad;
  assign accept = req_valid && req_ready;
  assign ram_we = accept && req_we && !fault;
  assign ram_re = accept && !req_we && !fault;

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .be   (req_be),
    .addr (off[AW+1:2]),
    .wdata(req_wdata),
    .rdata(ram_rdata)
  );

  // Read word lives in the RAM output register; rd_sel gates it.
  assign rsp_rdata = rd_sel ? ram_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            rsp_err   <= fault;
            rd_sel    <= !req_we && !fault;
            if (LATENCY == 1) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel    <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
